// File: rtl/alu_muldiv_seq_if.sv
// Request/response and shared-ALU signals of the multiply/divide sequencer.
//
// Handshake: the requester holds start=1 together with op/src_a/src_b for one
// cycle; the request is taken on that rising edge only when the sequencer is
// idle (busy=0), otherwise it is dropped with no effect. busy stays high until
// done has pulsed for exactly one cycle; result is valid in the done cycle and
// holds until the next accepted request. There is no back-pressure on done.
interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;

  // Requester side, which also closes the loop through the shared ALU.
  modport master (
    output start, op, src_a, src_b, alu_result,
    input  busy, done, result, alu_a, alu_b, alu_ctrl
  );

  // Sequencer side.
  modport slave (
    input  start, op, src_a, src_b, alu_result,
    output busy, done, result, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 32-bit unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the
// execute stage's add/subtract ALU for one shift-add or restoring-divide step
// per cycle. Carry/borrow out of the ALU are rebuilt from operand/result MSBs.
module alu_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_muldiv_seq_if.slave       bus,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  localparam logic [2:0] ALU_CTRL_ADD = 3'b000;
  localparam logic [2:0] ALU_CTRL_SUB = 3'b001;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  // Request is taken only in IDLE; divide by zero skips the iteration phase.
  logic accept;
  logic div_by_zero;
  logic last_iter;

  // Shift-in value for the divide step: partial remainder shifted left by one.
  logic [XLEN-1:0] rs;
  logic            r33;
  logic            carry;
  logic            borrow;
  logic            ge;

  assign accept      = (state_q == ST_IDLE) && bus.start;
  assign div_by_zero = bus.op[1] && (bus.src_b == '0);
  assign last_iter   = (cnt_q == LAST_CNT);
  assign rs          = {acc_q[XLEN-2:0], sh_q[XLEN-1]};
  assign r33         = acc_q[XLEN-1];
  assign dbg_state   = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = div_by_zero ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: status flags and the ALU drive.
  always_comb begin
    bus.busy     = (state_q != ST_IDLE);
    bus.done     = (state_q == ST_DONE);
    bus.result   = result_q;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_ctrl = ALU_CTRL_ADD;
    if (state_q == ST_CALC) begin
      bus.alu_b = b_q;
      if (op_q[1]) begin
        bus.alu_a    = rs;
        bus.alu_ctrl = ALU_CTRL_SUB;
      end else begin
        bus.alu_a    = acc_q;
        bus.alu_ctrl = ALU_CTRL_ADD;
      end
    end
  end

  // Carry of acc+B and borrow of rs-B, rebuilt from MSBs only.
  always_comb begin
    carry  = (acc_q[XLEN-1] & b_q[XLEN-1]) |
             ((acc_q[XLEN-1] | b_q[XLEN-1]) & ~bus.alu_result[XLEN-1]);
    borrow = (~rs[XLEN-1] & b_q[XLEN-1]) |
             ((~rs[XLEN-1] | b_q[XLEN-1]) & bus.alu_result[XLEN-1]);
    ge     = r33 | ~borrow;
  end

  // Datapath: latch on accept, one shift-add / restoring step per CALC cycle,
  // and capture the selected half into result on the way into DONE.
  always_comb begin
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = bus.op;
          b_d   = bus.src_b;
          cnt_d = '0;
          if (div_by_zero) begin
            result_d = (bus.op == OP_DIVU) ? '1 : bus.src_a;
          end else begin
            acc_d = '0;
            sh_d  = bus.src_a;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          acc_d = ge ? bus.alu_result : rs;
          sh_d  = {sh_q[XLEN-2:0], ge};
        end else if (sh_q[0]) begin
          acc_d = {carry, bus.alu_result[XLEN-1:1]};
          sh_d  = {bus.alu_result[0], sh_q[XLEN-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[XLEN-1:1]};
          sh_d  = {acc_q[0], sh_q[XLEN-1:1]};
        end
        if (last_iter) begin
          unique case (op_q)
            OP_MUL:   result_d = sh_d;
            OP_MULHU: result_d = acc_d;
            OP_DIVU:  result_d = sh_d;
            OP_REMU:  result_d = acc_d;
            default:  result_d = sh_d;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural add/sub ALU in the loop.
module tb_alu_muldiv_seq;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

  alu_muldiv_seq_if #(.XLEN(32)) bus ();

  alu_muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Shared execute-stage ALU: add for 000, subtract for 001.
  assign bus.alu_result = (bus.alu_ctrl == 3'b001) ? (bus.alu_a - bus.alu_b)
                                                   : (bus.alu_a + bus.alu_b);

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, follow it to done, and check timing,
  // result, busy coverage, ALU mode use and return to idle. Optional extra
  // start pulses (with junk operands) are driven in cycles p1/p2.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_done, input logic exp_sub,
                        input int p1, input int p2);
    int   done_cyc;
    logic busy_ok;
    logic sub_seen;
    logic ctrl_ok;
    done_cyc = -1;
    busy_ok  = 1'b1;
    sub_seen = 1'b0;
    ctrl_ok  = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.src_a = $urandom;
    bus.src_b = $urandom_range(1, 1000);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.alu_ctrl === 3'b001) sub_seen = 1'b1;
      if (bus.alu_ctrl !== 3'b000 && bus.alu_ctrl !== 3'b001) ctrl_ok = 1'b0;
      bus.start = (cyc == p1) || (cyc == p2);
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_busy_span"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_alu_sub_use"}, {31'b0, sub_seen}, {31'b0, exp_sub});
    chk({tag, "_alu_ctrl_legal"}, {31'b0, ctrl_ok}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_idle_after"}, {30'b0, dbg_state}, 32'd0);
    chk({tag, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
    chk({tag, "_result_hold"}, bus.result, exp_res);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    #2;
    // Reset state.
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Multiply.
    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 33, 1'b0, 0, 0);
    run_op("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, 0, 0);
    run_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0, 0, 0);
    run_op("mul_shift", 2'b00, 32'h1234_5678, 32'h10, 32'h2345_6780, 33, 1'b0, 0, 0);
    run_op("mulhu_shift", 2'b01, 32'h1234_5678, 32'h10, 32'h0000_0001, 33, 1'b0, 0, 0);

    // Divide.
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 33, 1'b1, 0, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b1, 0, 0);
    run_op("divu_bigdiv", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b1, 0, 0);
    run_op("remu_bigdiv", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b1, 0, 0);
    run_op("divu_by1", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1, 0, 0);

    // Divide by zero: immediate done, ALU left in add mode.
    run_op("divu_zero", 2'b10, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 0, 0);
    run_op("remu_zero", 2'b11, 32'd1234, 32'd0, 32'd1234, 1, 1'b0, 0, 0);

    // Stray starts during CALC (cycle 5) and in the DONE cycle (33) are dropped.
    run_op("mul_3x5_stray", 2'b00, 32'd3, 32'd5, 32'd15, 33, 1'b0, 5, 33);
    @(negedge clk);
    chk("stray_no_queue_busy", {31'b0, bus.busy}, 32'd0);
    chk("stray_no_queue_result", bus.result, 32'd15);
    run_op("mul_after_stray", 2'b00, 32'd4, 32'd4, 32'd16, 33, 1'b0, 0, 0);

    // Asynchronous abort in cycle 10 of a DIVU.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre_busy", {31'b0, bus.busy}, 32'd1);
    chk("abort_pre_ctrl", {29'b0, bus.alu_ctrl}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_alu_a", bus.alu_a, 32'd0);
    chk("abort_alu_b", bus.alu_b, 32'd0);
    chk("abort_alu_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);
    begin
      logic done_seen;
      done_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (i == 3) rst_n = 1'b1;
        if (bus.done === 1'b1) done_seen = 1'b1;
      end
      chk("abort_no_done", {31'b0, done_seen}, 32'd0);
    end
    run_op("divu_9_3", 2'b10, 32'd9, 32'd3, 32'd3, 33, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
